// File: rtl/otter_intr_ctrl_if.sv
`default_nettype none
// ============================================================================
// otter_intr_ctrl_if : interrupt lines, IOBUS and CPU handshake bundle
// Rev 1.0
// ============================================================================
interface otter_intr_ctrl_if #(
  parameter int N_SRC = 8
);
  logic [N_SRC-1:0] IRQ_IN;
  logic [31:0]      IO_ADDR;
  logic             IO_WR;
  logic [31:0]      IO_WDATA;
  logic [31:0]      IO_RDATA;
  logic             INT_ACK;
  logic             MRET_EXEC;
  logic             CPU_INTR;

  // master = CPU / system side, slave = the interrupt controller
  modport master (
    output IRQ_IN, IO_ADDR, IO_WR, IO_WDATA, INT_ACK, MRET_EXEC,
    input  IO_RDATA, CPU_INTR
  );

  modport slave (
    input  IRQ_IN, IO_ADDR, IO_WR, IO_WDATA, INT_ACK, MRET_EXEC,
    output IO_RDATA, CPU_INTR
  );
endinterface
`default_nettype wire

// File: rtl/otter_intr_ctrl.sv
`default_nettype none
// ============================================================================
// otter_intr_ctrl : N-source edge-triggered interrupt controller for OTTER
// Rev 1.0
// ============================================================================
module otter_intr_ctrl #(
  parameter int          N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1100_0200
) (
  input  logic             INTC_CLK,
  input  logic             INTC_RST_N,
  otter_intr_ctrl_if.slave bus
);

  localparam int          ID_W         = 5;
  localparam logic [31:0] ADDR_ENABLE  = BASE_ADDR;
  localparam logic [31:0] ADDR_PENDING = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_CAUSE   = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] sync1_q, sync1_d;
  logic [N_SRC-1:0] sync2_q, sync2_d;
  logic [N_SRC-1:0] prev_q, prev_d;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             cpu_intr_q, cpu_intr_d;

  logic [N_SRC-1:0] irq_rise;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] id_mask;
  logic [ID_W-1:0]  sel_id;
  logic             wr_enable;
  logic             wr_pending;
  logic             ack_take;
  logic             id_still_live;
  logic [31:0]      rdata;

  // Input path, priority selection and register decode
  always_comb begin
    sync1_d  = bus.IRQ_IN;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    irq_rise = sync2_q & ~prev_q;

    cand   = pending_q & enable_q;
    sel_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_id = ID_W'(i);
      end
    end

    id_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      id_mask[i] = (id_q == ID_W'(i));
    end
    id_still_live = (|(enable_q & id_mask)) && (|(pending_q & id_mask));

    wr_enable  = bus.IO_WR && (bus.IO_ADDR == ADDR_ENABLE);
    wr_pending = bus.IO_WR && (bus.IO_ADDR == ADDR_PENDING);

    rdata = '0;
    if (bus.IO_ADDR == ADDR_ENABLE) begin
      rdata[N_SRC-1:0] = enable_q;
    end else if (bus.IO_ADDR == ADDR_PENDING) begin
      rdata[N_SRC-1:0] = pending_q;
    end else if (bus.IO_ADDR == ADDR_CAUSE) begin
      if (state_q != ST_IDLE) begin
        rdata[31]       = 1'b1;
        rdata[ID_W-1:0] = id_q;
      end
    end
  end

  // Handshake FSM next state; the latched ID is frozen outside IDLE
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (|cand) begin
          id_d    = sel_id;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.INT_ACK) begin
          state_d = ST_ACTIVE;
        end else if (!id_still_live) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (bus.MRET_EXEC) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cpu_intr_d = (state_d == ST_REQ);
  end

  // Pending and enable update; a new edge is applied last so set beats clear
  always_comb begin
    ack_take = (state_q == ST_REQ) && bus.INT_ACK;

    enable_d = enable_q;
    if (wr_enable) begin
      enable_d = bus.IO_WDATA[N_SRC-1:0];
    end

    pending_d = pending_q;
    if (wr_pending) begin
      pending_d = pending_d & ~bus.IO_WDATA[N_SRC-1:0];
    end
    if (ack_take) begin
      pending_d = pending_d & ~id_mask;
    end
    pending_d = pending_d | irq_rise;
  end

  always_ff @(posedge INTC_CLK or negedge INTC_RST_N) begin
    if (!INTC_RST_N) begin
      state_q    <= ST_IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      enable_q   <= '0;
      pending_q  <= '0;
      id_q       <= '0;
      cpu_intr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      id_q       <= id_d;
      cpu_intr_q <= cpu_intr_d;
    end
  end

  assign bus.IO_RDATA = rdata;
  assign bus.CPU_INTR = cpu_intr_q;

  // Write-data bits above the source count have no register behind them
  if (N_SRC < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^bus.IO_WDATA[31:N_SRC];
  end

endmodule
`default_nettype wire

// File: tb/tb_otter_intr_ctrl.sv
`default_nettype none
// ============================================================================
// tb_otter_intr_ctrl : directed handshake checks plus randomized scoreboard
// Rev 1.0
// ============================================================================
module tb_otter_intr_ctrl;
  localparam int          N_SRC   = 8;
  localparam logic [31:0] BASE    = 32'h1100_0200;
  localparam logic [31:0] A_EN    = BASE;
  localparam logic [31:0] A_PEND  = BASE + 32'd4;
  localparam logic [31:0] A_CAUSE = BASE + 32'd8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  otter_intr_ctrl_if #(.N_SRC(N_SRC)) bus ();

  otter_intr_ctrl #(.N_SRC(N_SRC), .BASE_ADDR(BASE)) dut (
    .INTC_CLK  (clk),
    .INTC_RST_N(rst_n),
    .bus       (bus)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_q[$];
  bit   svc_en   = 1'b0;
  bit   svc_busy = 1'b0;
  logic [7:0] en_r, fire_r;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic chk_intr(input string name, input logic exp);
    check(name, {31'b0, bus.CPU_INTR}, {31'b0, exp});
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.IO_ADDR = a;
    #1;
    d = bus.IO_RDATA;
  endtask

  task automatic chk_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.IO_ADDR  = a;
    bus.IO_WDATA = d;
    bus.IO_WR    = 1'b1;
    @(negedge clk);
    bus.IO_WR    = 1'b0;
  endtask

  task automatic pulse_irq(input logic [7:0] m, input int cyc);
    @(negedge clk);
    bus.IRQ_IN = m;
    repeat (cyc) @(negedge clk);
    bus.IRQ_IN = '0;
  endtask

  task automatic wait_intr(input string name, input int maxc);
    int k = 0;
    while (bus.CPU_INTR !== 1'b1 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk_intr(name, 1'b1);
  endtask

  task automatic ack();
    @(negedge clk); bus.INT_ACK = 1'b1;
    @(negedge clk); bus.INT_ACK = 1'b0;
  endtask

  task automatic mret();
    @(negedge clk); bus.MRET_EXEC = 1'b1;
    @(negedge clk); bus.MRET_EXEC = 1'b0;
  endtask

  task automatic ack_checked(input string name);
    @(negedge clk); bus.INT_ACK = 1'b1;
    @(posedge clk); #1;
    chk_intr(name, 1'b0);
    @(negedge clk); bus.INT_ACK = 1'b0;
  endtask

  // mret at edge E -> IDLE after E, REQ again after E+1 when a candidate remains
  task automatic mret_reassert(input string name);
    @(negedge clk); bus.MRET_EXEC = 1'b1;
    @(posedge clk); #1;
    chk_intr({name, "_idle"}, 1'b0);
    @(negedge clk); bus.MRET_EXEC = 1'b0;
    @(posedge clk); #1;
    chk_intr({name, "_req"}, 1'b1);
  endtask

  // Scoreboard monitor: acts as the CPU and checks every request it sees
  initial begin : monitor
    logic [31:0] cause;
    int          exp_id;
    forever begin
      @(negedge clk);
      if (svc_en && bus.CPU_INTR === 1'b1) begin
        svc_busy = 1'b1;
        rd(A_CAUSE, cause);
        if (exp_q.size() == 0) begin
          chk_intr("sb_unexpected_req", 1'b0);
        end else begin
          exp_id = exp_q.pop_front();
          check("sb_cause", cause, {1'b1, 26'b0, exp_id[4:0]});
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.INT_ACK = 1'b1;
        @(negedge clk);
        bus.INT_ACK = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.MRET_EXEC = 1'b1;
        @(negedge clk);
        bus.MRET_EXEC = 1'b0;
        svc_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    bus.IRQ_IN = '0; bus.IO_ADDR = '0; bus.IO_WR = 1'b0; bus.IO_WDATA = '0;
    bus.INT_ACK = 1'b0; bus.MRET_EXEC = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_intr("rst_intr", 1'b0);
    rst_n = 1'b1;
    chk_reg("rst_enable", A_EN, 32'h0);
    chk_reg("rst_pending", A_PEND, 32'h0);
    chk_reg("rst_cause", A_CAUSE, 32'h0);
    chk_reg("unmapped", BASE + 32'd12, 32'h0);

    // Single source: four-edge latency, ack, mret
    wr(A_EN, 32'h04);
    chk_reg("enable_rb", A_EN, 32'h04);
    @(negedge clk);
    bus.IRQ_IN = 8'h04;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      chk_intr($sformatf("lat_e%0d", e), (e == 4));
    end
    @(negedge clk); bus.IRQ_IN = '0;
    chk_reg("single_cause", A_CAUSE, 32'h8000_0002);
    ack_checked("single_ack");
    chk_reg("single_pend_clr", A_PEND, 32'h0);
    chk_reg("single_active_cause", A_CAUSE, 32'h8000_0002);
    mret();
    chk_reg("single_mret_cause", A_CAUSE, 32'h0);
    wr(A_CAUSE, 32'hFFFF_FFFF);
    chk_reg("cause_ro", A_CAUSE, 32'h0);

    // Priority: sources 5 and 1 together
    wr(A_EN, 32'hFF);
    pulse_irq(8'h22, 1);
    wait_intr("prio_req1", 20);
    chk_reg("prio_cause1", A_CAUSE, 32'h8000_0001);
    ack_checked("prio_ack1");
    mret_reassert("prio");
    chk_reg("prio_cause2", A_CAUSE, 32'h8000_0005);
    ack(); mret();
    repeat (6) @(negedge clk);
    chk_intr("prio_quiet", 1'b0);
    chk_reg("prio_pend", A_PEND, 32'h0);

    // Masking and software withdraw
    wr(A_EN, 32'h00);
    pulse_irq(8'h08, 1);
    repeat (6) @(negedge clk);
    chk_intr("mask_intr", 1'b0);
    chk_reg("mask_pend", A_PEND, 32'h08);
    wr(A_EN, 32'h08);
    chk_intr("mask_en_e", 1'b0);
    @(posedge clk); #1;
    chk_intr("mask_en_e1", 1'b1);
    wr(A_PEND, 32'h08);
    @(posedge clk); #1;
    chk_intr("withdraw_intr", 1'b0);
    chk_reg("withdraw_cause", A_CAUSE, 32'h0);
    chk_reg("withdraw_pend", A_PEND, 32'h0);

    // Collision: new edge on source 0 in the same cycle as its ack
    wr(A_EN, 32'h01);
    pulse_irq(8'h01, 1);
    wait_intr("coll_req", 20);
    chk_reg("coll_cause", A_CAUSE, 32'h8000_0000);
    @(negedge clk); bus.IRQ_IN = 8'h01;
    @(negedge clk);
    @(negedge clk); bus.INT_ACK = 1'b1;
    @(posedge clk); #1;
    chk_intr("coll_ack_intr", 1'b0);
    chk_reg("coll_pend", A_PEND, 32'h01);
    @(negedge clk); bus.INT_ACK = 1'b0; bus.IRQ_IN = '0;
    mret_reassert("coll");
    ack(); mret();

    // Nesting: no preemption while ACTIVE
    wr(A_EN, 32'h11);
    pulse_irq(8'h10, 1);
    wait_intr("nest_req", 20);
    chk_reg("nest_cause", A_CAUSE, 32'h8000_0004);
    ack_checked("nest_ack");
    pulse_irq(8'h01, 1);
    repeat (6) @(negedge clk);
    chk_intr("nest_intr", 1'b0);
    chk_reg("nest_cause_hold", A_CAUSE, 32'h8000_0004);
    chk_reg("nest_pend", A_PEND, 32'h01);
    mret_reassert("nest");
    chk_reg("nest_cause2", A_CAUSE, 32'h8000_0000);
    ack(); mret();

    // Reset mid-request
    wr(A_EN, 32'h04);
    pulse_irq(8'h04, 1);
    wait_intr("rstmid_req", 20);
    #2 rst_n = 1'b0;
    #1 chk_intr("rstmid_async", 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_reg("rstmid_enable", A_EN, 32'h0);
    chk_reg("rstmid_pending", A_PEND, 32'h0);
    chk_reg("rstmid_cause", A_CAUSE, 32'h0);

    // Randomized scenarios: service order is the enabled fired set, ascending
    svc_en = 1'b1;
    for (int s = 0; s < 24; s++) begin
      en_r   = 8'($urandom);
      fire_r = 8'($urandom_range(1, 255));
      wr(A_EN, {24'b0, en_r});
      for (int i = 0; i < N_SRC; i++) begin
        if (fire_r[i] && en_r[i]) exp_q.push_back(i);
      end
      pulse_irq(fire_r, $urandom_range(1, 3));
      k = 0;
      while ((exp_q.size() != 0 || svc_busy || bus.CPU_INTR === 1'b1) && k < 400) begin
        @(negedge clk);
        k++;
      end
      check("scn_drain", exp_q.size(), 32'd0);
      exp_q.delete();
      repeat (8) @(negedge clk);
      while (svc_busy) @(negedge clk);
      chk_reg("scn_pending", A_PEND, {24'b0, fire_r & ~en_r});
      wr(A_PEND, 32'hFF);
    end
    svc_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
